// File: rtl/alu_share_arbiter_if.sv
// Request/response handshakes and ALU drive bus
// shared between the arbiter and its clients.
interface alu_share_arbiter_if #(
    parameter int W = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_flag;
    logic [W-1:0] alu_ina;
    logic [W-1:0] alu_inb;
    logic [2:0]   alu_control;
    logic         alu_flagwrite;
    logic [W-1:0] alu_result;
    logic         alu_flag;
    logic         busy;
    logic         grant_id;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        input  alu_result, alu_flag,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid,
        output rsp_result, rsp_flag,
        output alu_ina, alu_inb,
        output alu_control, alu_flagwrite,
        output busy, grant_id
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        output alu_result, alu_flag,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_flag,
        input  alu_ina, alu_inb,
        input  alu_control, alu_flagwrite,
        input  busy, grant_id
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU
// between two requesters: IDLE -> EXEC -> RESP.
module alu_share_arbiter #(
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t       r_state;
    logic         r_last;
    logic         r_grant;
    logic [2:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_result;

    logic w_any;
    logic w_win;
    logic w_take;
    logic w_done;

    assign w_any = bus.req0_valid | bus.req1_valid;

    // Contention goes to the port that did not win last time.
    assign w_win = (bus.req0_valid && bus.req1_valid)
                 ? ~r_last : bus.req1_valid;

    assign w_take = (r_state == S_IDLE) && !rst && w_any;
    assign w_done = r_grant ? bus.rsp1_ready : bus.rsp0_ready;

    assign bus.req0_ready = w_take && !w_win;
    assign bus.req1_ready = w_take && w_win;

    assign bus.rsp0_valid = (r_state == S_RESP) && !r_grant;
    assign bus.rsp1_valid = (r_state == S_RESP) && r_grant;
    assign bus.rsp_result = r_result;
    assign bus.rsp_flag   = bus.alu_flag;

    assign bus.alu_ina     = r_a;
    assign bus.alu_inb     = r_b;
    assign bus.alu_control = r_op;

    // Suppressed under reset so an aborted sub never touches the flag.
    assign bus.alu_flagwrite = (r_state == S_EXEC) && !rst
                             && (r_op == 3'b001);

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.grant_id = r_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_grant  <= 1'b0;
            r_op     <= 3'b000;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op    <= w_win ? bus.req1_op : bus.req0_op;
                        r_a     <= w_win ? bus.req1_a  : bus.req0_a;
                        r_b     <= w_win ? bus.req1_b  : bus.req0_b;
                        r_grant <= w_win;
                        r_last  <= w_win;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= bus.alu_result;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
